// File: rtl/spio_route_demux.sv
// One-packet head register feeding two registered output ports, steered by a
// single route bit; a head blocked for WAIT_CYCLES cycles is discarded and counted.
module spio_route_demux #(
  parameter int PKT_BITS    = 72,
  parameter int ROUTE_BIT   = 0,
  parameter int WAIT_CYCLES = 16
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic [PKT_BITS-1:0] DATA_IN,
  input  logic                VLD_IN,
  output logic                RDY_OUT,
  output logic [PKT_BITS-1:0] DATA0_OUT,
  output logic                VLD0_OUT,
  input  logic                RDY0_IN,
  output logic [PKT_BITS-1:0] DATA1_OUT,
  output logic                VLD1_OUT,
  input  logic                RDY1_IN,
  output logic                DROPPED_OUT,
  output logic [15:0]         DROP_COUNT_OUT
);

  localparam int CTR_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CTR_W-1:0] WAIT_LAST = CTR_W'((WAIT_CYCLES < 1) ? 0 : WAIT_CYCLES - 1);
  localparam bit DROP_EN = (WAIT_CYCLES != 0);

  logic [PKT_BITS-1:0] head_data;
  logic                head_vld;
  logic [CTR_W-1:0]    wait_ctr;

  logic tgt;
  logic cansend0;
  logic cansend1;
  logic cansend_t;
  logic move;
  logic drop;
  logic load;

  // Handshake: a word moves on a rising edge where valid and ready are both
  // high; valid never looks at ready, and an output slot accepts a new word
  // when it is empty or its current word is leaving on the same edge.
  always_comb begin
    tgt       = head_data[ROUTE_BIT];
    cansend0  = !VLD0_OUT || RDY0_IN;
    cansend1  = !VLD1_OUT || RDY1_IN;
    cansend_t = tgt ? cansend1 : cansend0;
    move      = head_vld && cansend_t;
    drop      = DROP_EN && head_vld && !move && (wait_ctr == WAIT_LAST);
    RDY_OUT   = !RESET_IN && (!head_vld || move || drop);
    load      = VLD_IN && RDY_OUT;
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      head_data      <= '0;
      head_vld       <= 1'b0;
      wait_ctr       <= '0;
      DATA0_OUT      <= '0;
      VLD0_OUT       <= 1'b0;
      DATA1_OUT      <= '0;
      VLD1_OUT       <= 1'b0;
      DROPPED_OUT    <= 1'b0;
      DROP_COUNT_OUT <= '0;
    end else begin
      if (cansend0) begin
        if (move && !tgt) begin
          DATA0_OUT <= head_data;
          VLD0_OUT  <= 1'b1;
        end else begin
          VLD0_OUT  <= 1'b0;
        end
      end
      if (cansend1) begin
        if (move && tgt) begin
          DATA1_OUT <= head_data;
          VLD1_OUT  <= 1'b1;
        end else begin
          VLD1_OUT  <= 1'b0;
        end
      end

      // A load on the same edge as a move/drop simply replaces the head.
      if (load) begin
        head_data <= DATA_IN;
        head_vld  <= 1'b1;
      end else if (move || drop) begin
        head_vld  <= 1'b0;
      end

      // Counts blocked cycles of the current head only.
      if (load || !head_vld || move || drop) begin
        wait_ctr <= '0;
      end else begin
        wait_ctr <= wait_ctr + CTR_W'(1);
      end

      DROPPED_OUT <= drop;
      if (drop && (DROP_COUNT_OUT != 16'hFFFF)) begin
        DROP_COUNT_OUT <= DROP_COUNT_OUT + 16'd1;
      end
    end
  end

endmodule

// File: doc/spio_route_demux.md
SPIO_ROUTE_DEMUX -- requirements
Module: spio_route_demux

Interface
REQ-001 The block SHALL have parameter PKT_BITS, default 72, packet width in bits.
REQ-002 The block SHALL have parameter ROUTE_BIT, default 0, index of the packet bit selecting the output port (0 -> port 0, 1 -> port 1).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 16, number of consecutive blocked cycles before the head packet is dropped; 0 disables dropping.
REQ-004 The block SHALL have port CLK_IN, input, 1, sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET_IN, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have ports DATA_IN input PKT_BITS, VLD_IN input 1, RDY_OUT output 1: the incoming packet stream.
REQ-007 The block SHALL have ports DATA0_OUT output PKT_BITS, VLD0_OUT output 1, RDY0_IN input 1: output port 0.
REQ-008 The block SHALL have ports DATA1_OUT output PKT_BITS, VLD1_OUT output 1, RDY1_IN input 1: output port 1.
REQ-009 The block SHALL have port DROPPED_OUT, output, 1, single-cycle pulse per discarded packet.
REQ-010 The block SHALL have port DROP_COUNT_OUT, output, 16, saturating count of discarded packets.

Function
REQ-011 A transfer on any port SHALL occur on a rising edge where the port's valid and ready are both high; valid SHALL NOT depend on ready.
REQ-012 The block SHALL hold one head register (head_data, head_vld); it SHALL load DATA_IN and set head_vld on every input transfer.
REQ-013 Target t SHALL be head_data[ROUTE_BIT]; cansend_t SHALL be !VLDt_OUT || RDYt_IN.
REQ-014 move SHALL be head_vld && cansend_t; on move, DATAt_OUT <= head_data and VLDt_OUT <= 1.
REQ-015 For each port n, when cansend_n and no move targets n, VLDn_OUT SHALL become 0 and DATAn_OUT SHALL hold its value; when !cansend_n, DATAn_OUT/VLDn_OUT SHALL hold.
REQ-016 RDY_OUT SHALL be !RESET_IN && (!head_vld || move || drop), combinational; a load and a move/drop in the same cycle SHALL replace the head.
REQ-017 head_vld SHALL clear on move or drop when no input transfer occurs in that cycle.
REQ-018 Latency SHALL be 2 cycles: input transfer at edge N gives output valid after edge N+1 when the target is free; sustained throughput SHALL be 1 packet/cycle per unblocked target.
REQ-019 Ordering SHALL be preserved; a head blocked on one port SHALL block packets to the other port (head-of-line blocking is intended).
REQ-020 wait_ctr (width ceil(log2(WAIT_CYCLES+1)), minimum 1) SHALL reset to 0 whenever the head is loaded or empty, and SHALL increment each cycle head_vld && !move.
REQ-021 drop SHALL be (WAIT_CYCLES != 0) && head_vld && !move && wait_ctr == WAIT_CYCLES-1: the head is discarded at that edge, after exactly WAIT_CYCLES blocked cycles.
REQ-022 DROPPED_OUT SHALL be registered and high for exactly the one cycle following each drop edge; consecutive drops SHALL produce consecutive pulses.
REQ-023 DROP_COUNT_OUT SHALL increment at each drop edge and saturate at 0xFFFF.
REQ-024 A dropped packet SHALL NOT appear on either output; outputs already valid SHALL be unaffected by a drop.

Reset
REQ-025 While RESET_IN is high at an edge: head_vld, VLD0_OUT, VLD1_OUT, DROPPED_OUT SHALL become 0; DATA0_OUT, DATA1_OUT, head_data, wait_ctr, DROP_COUNT_OUT SHALL become 0.
REQ-026 RDY_OUT SHALL be 0 in any cycle RESET_IN is high; reset mid-packet SHALL discard the head and both output registers without any transfer.
REQ-027 Outputs SHALL be valid from the first edge with RESET_IN low; no inputs are sampled during reset.

Verification (PKT_BITS=72, ROUTE_BIT=0, WAIT_CYCLES=4)
REQ-028 Both RDYn_IN=1, send 0x..10,0x..11,0x..12 back-to-back -> port 0 gets 0x10,0x12, port 1 gets 0x11, each 2 cycles after acceptance, RDY_OUT stays 1.
REQ-029 RDY0_IN=0, send 0x20 then 0x22 -> 0x20 held on port 0, 0x22 in head; after 4 blocked cycles 0x22 dropped, DROPPED_OUT one-cycle pulse, DROP_COUNT_OUT=1.
REQ-030 RDY0_IN=0 with port 0 full, head 0x30, then 0x31 offered -> 0x31 waits behind 0x30 (RDY_OUT=0); release RDY0_IN at blocked cycle 2 -> 0x30 then 0x31 delivered, no drop.
REQ-031 WAIT_CYCLES=0, RDY0_IN=0 for 100 cycles with head to port 0 -> no drop, DROPPED_OUT never high, packet delivered when released.
REQ-032 Force DROP_COUNT_OUT to 0xFFFF via 65535 drops, one more drop -> stays 0xFFFF, DROPPED_OUT still pulses.
REQ-033 Assert RESET_IN for 1 cycle with both outputs valid and head full -> all valids 0, RDY_OUT 0 during reset, 1 next cycle, no output transfer.
